// File: rtl/ex_stage.sv
// ex_stage: execute stage (logic/shift/arith in one cycle); define EX_DIV_EN for the iterative restoring divider
module ex_stage #(
   parameter int DW    = 32,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [6:0]    ex_aluop,
   input  logic [2:0]    ex_alusel,
   input  logic [6:0]    ex_alusel2,
   input  logic [DW-1:0] ex_reg1,
   input  logic [DW-1:0] ex_reg2,
   input  logic [4:0]    ex_wd,
   input  logic          ex_wreg,
   input  logic          ex_flush,
   output logic [4:0]    ex_wd_o,
   output logic          ex_wreg_o,
   output logic [DW-1:0] ex_wdata_o,
   output logic          ex_stallreq
);
   localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_ARITH = 3'd3, SEL_DIV = 3'd4;
   logic [$clog2(DW)-1:0] sh;
   logic [DW-1:0] logic_res, shift_res, arith_res, sra_res, res;
   logic op_ok;
   assign op_ok = ex_aluop < 7'd4;
   assign sh = ex_reg2[$clog2(DW)-1:0];
   assign sra_res = $signed(ex_reg1) >>> sh;
   // single-cycle unit results, undefined op codes give zero
   always_comb begin
      logic_res = ex_aluop == 7'd0 ? ex_reg1 & ex_reg2 :
                  ex_aluop == 7'd1 ? ex_reg1 | ex_reg2 :
                  ex_aluop == 7'd2 ? ex_reg1 ^ ex_reg2 :
                  ex_aluop == 7'd3 ? ~(ex_reg1 | ex_reg2) : '0;
      shift_res = ex_aluop == 7'd0 ? ex_reg1 << sh :
                  ex_aluop == 7'd1 ? ex_reg1 >> sh :
                  ex_aluop == 7'd2 ? sra_res : '0;
      arith_res = ex_aluop == 7'd0 ? ex_reg1 + ex_reg2 :
                  ex_aluop == 7'd1 ? ex_reg1 - ex_reg2 :
                  ex_aluop == 7'd2 ? {{(DW-1){1'b0}}, $signed(ex_reg1) < $signed(ex_reg2)} :
                  ex_aluop == 7'd3 ? {{(DW-1){1'b0}}, ex_reg1 < ex_reg2} : '0;
      res = ex_alusel == SEL_LOGIC ? logic_res :
            ex_alusel == SEL_SHIFT ? shift_res :
            ex_alusel == SEL_ARITH ? arith_res : '0;
   end
`ifdef EX_DIV_EN
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};
   logic [1:0] state;
   logic [CNT_W-1:0] cnt;
   logic [DW-1:0] quo, rem, dvs, a_abs, b_abs, q_fix, r_fix, sp_res;
   logic [DW:0] trial;
   logic neg_q, neg_r, is_rem, is_div, sgn, ovf, dz, start;
   logic unused_in;
   assign unused_in = ^ex_alusel2;
   assign is_div = ex_alusel == SEL_DIV && op_ok;
   assign sgn = ~ex_aluop[0];
   assign dz = ex_reg2 == '0;
   assign ovf = sgn && ex_reg1 == MSB && &ex_reg2;
   assign start = state == IDLE && is_div && !dz && !ovf && !ex_flush;
   assign a_abs = sgn && ex_reg1[DW-1] ? -ex_reg1 : ex_reg1;
   assign b_abs = sgn && ex_reg2[DW-1] ? -ex_reg2 : ex_reg2;
   assign trial = {rem, quo[DW-1]} - {1'b0, dvs};
   assign q_fix = neg_q ? -quo : quo;
   assign r_fix = neg_r ? -rem : rem;
   assign sp_res = dz ? (ex_aluop[1] ? ex_reg1 : '1) : ovf ? (ex_aluop[1] ? '0 : MSB) : '0;
   // divider FSM: latch magnitudes on start, one restoring step per BUSY cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_rem <= 1'b0;
      end else if (state != IDLE && ex_flush) state <= IDLE;
      else if (start) begin
         state  <= BUSY;
         cnt    <= '0;
         quo    <= a_abs;
         rem    <= '0;
         dvs    <= b_abs;
         neg_q  <= sgn && (ex_reg1[DW-1] ^ ex_reg2[DW-1]);
         neg_r  <= sgn && ex_reg1[DW-1];
         is_rem <= ex_aluop[1];
      end else if (state == BUSY) begin
         cnt <= cnt + 1'b1;
         quo <= {quo[DW-2:0], ~trial[DW]};
         rem <= trial[DW] ? {rem[DW-2:0], quo[DW-1]} : trial[DW-1:0];
         if (cnt == CNT_W'(DW - 1)) state <= DONE;
      end else if (state == DONE) state <= IDLE;
   // output mux: stall while dividing, signed result in DONE, zeros while in reset
   always_comb begin
      ex_wd_o     = ex_wd;
      ex_wreg_o   = ex_wreg && !ex_flush;
      ex_stallreq = 1'b0;
      ex_wdata_o  = res;
      if (state == BUSY) begin
         ex_stallreq = !ex_flush;
         ex_wreg_o   = 1'b0;
         ex_wdata_o  = '0;
      end else if (state == DONE) ex_wdata_o = is_rem ? r_fix : q_fix;
      else if (start) begin
         ex_stallreq = 1'b1;
         ex_wreg_o   = 1'b0;
         ex_wdata_o  = '0;
      end else if (ex_alusel == SEL_DIV) ex_wdata_o = is_div ? sp_res : '0;
      if (rst) begin
         ex_wd_o     = '0;
         ex_wreg_o   = 1'b0;
         ex_wdata_o  = '0;
         ex_stallreq = 1'b0;
      end
   end
`else
   logic unused_in;
   assign unused_in = ^{ex_alusel2, clk, op_ok};
   // no divider: DIV retires immediately without writing back
   always_comb begin
      ex_wd_o     = rst ? 5'd0 : ex_wd;
      ex_wreg_o   = !rst && ex_wreg && !ex_flush && ex_alusel != SEL_DIV;
      ex_wdata_o  = rst || ex_alusel == SEL_DIV ? '0 : res;
      ex_stallreq = 1'b0;
   end
`endif
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage with a behavioural reference model (honours EX_DIV_EN)
module tb_ex_stage;
   typedef struct {
      logic [31:0] data;
      logic        wreg;
      logic [4:0]  wd;
      int          stall;
      bit          chk_data;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic [6:0]  ex_aluop = '0, ex_alusel2 = '0;
   logic [2:0]  ex_alusel = 3'd3;
   logic [31:0] ex_reg1 = 32'd1, ex_reg2 = 32'd2;
   logic [4:0]  ex_wd = 5'd9;
   logic        ex_wreg = 1'b1, ex_flush = 1'b0;
   logic [4:0]  ex_wd_o;
   logic        ex_wreg_o, ex_stallreq;
   logic [31:0] ex_wdata_o;
   exp_t        sb[$];
   int          checks = 0, errors = 0, issued = 0, retired = 0, stall_cnt = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_alusel2(ex_alusel2),
      .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_flush(ex_flush),
      .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_wdata_o(ex_wdata_o), .ex_stallreq(ex_stallreq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] sel, input logic [6:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] wd, input logic wreg, input logic flush);
      exp_t e;
      e.wd = wd;
      e.wreg = wreg && !flush;
      e.data = 32'd0;
      e.stall = 0;
      e.chk_data = !flush;
      if (sel == 3'd1) begin
         if (op == 0) e.data = a & b;
         else if (op == 1) e.data = a | b;
         else if (op == 2) e.data = a ^ b;
         else if (op == 3) e.data = ~(a | b);
      end else if (sel == 3'd2) begin
         if (op == 0) e.data = a << b[4:0];
         else if (op == 1) e.data = a >> b[4:0];
         else if (op == 2) e.data = $signed(a) >>> b[4:0];
      end else if (sel == 3'd3) begin
         if (op == 0) e.data = a + b;
         else if (op == 1) e.data = a - b;
         else if (op == 2) e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         else if (op == 3) e.data = (a < b) ? 32'd1 : 32'd0;
      end else if (sel == 3'd4) begin
`ifdef EX_DIV_EN
         if (op < 4) begin
            if (b == 0) e.data = op[1] ? a : 32'hFFFF_FFFF;
            else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.data = op[1] ? 32'd0 : 32'h8000_0000;
            else begin
               if (op == 0) e.data = $signed(a) / $signed(b);
               else if (op == 1) e.data = a / b;
               else if (op == 2) e.data = $signed(a) % $signed(b);
               else e.data = a % b;
               if (!flush) e.stall = 33;
            end
         end
`else
         e.wreg = 1'b0;
`endif
      end
      return e;
   endfunction

   // call at posedge+1; returns at posedge+1 after the instruction retires
   task automatic issue(input logic [2:0] sel, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg, input logic flush);
      ex_alusel = sel; ex_aluop = op; ex_reg1 = a; ex_reg2 = b; ex_wd = wd; ex_wreg = wreg; ex_flush = flush;
      ex_alusel2 = 7'($urandom);
      sb.push_back(model(sel, op, a, b, wd, wreg, flush));
      issued++;
      for (int i = 0; i < 100 && retired != issued; i++) @(posedge clk);
      if (retired != issued) begin
         $display("FAIL timeout: retired %0d expected %0d", retired, issued);
         $fatal(1, "no retirement");
      end
      #1;
   endtask

   // monitor: counts stall cycles, pops and compares when the stage presents a result
   initial forever begin
      @(negedge clk);
      if (issued != retired) begin
         if (ex_stallreq) begin
            stall_cnt++;
            chk("wreg_during_stall", {31'd0, ex_wreg_o}, 32'd0);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            retired++;
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wd_o", {27'd0, ex_wd_o}, {27'd0, e.wd});
            chk("wreg_o", {31'd0, ex_wreg_o}, {31'd0, e.wreg});
            if (e.chk_data) chk("wdata", ex_wdata_o, e.data);
            chk("stall_cycles", stall_cnt, e.stall);
            stall_cnt = 0;
            retired++;
         end
      end
   end

   initial begin
      logic [31:0] a, b;
      @(negedge clk);
      chk("rst_wd_o", {27'd0, ex_wd_o}, 32'd0);
      chk("rst_wreg_o", {31'd0, ex_wreg_o}, 32'd0);
      chk("rst_wdata", ex_wdata_o, 32'd0);
      chk("rst_stall", {31'd0, ex_stallreq}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      issue(3, 0, 32'h7FFF_FFFF, 32'h1, 5, 1, 0);
      issue(2, 2, 32'hF000_0000, 32'd4, 6, 1, 0);
      issue(3, 2, 32'hFFFF_FFFF, 32'h1, 7, 1, 0);
      issue(4, 0, -32'sd7, 32'd2, 8, 1, 0);
      issue(4, 2, -32'sd7, 32'd2, 8, 1, 0);
      issue(4, 1, 32'd100, 32'd0, 9, 1, 0);
      issue(4, 0, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1, 0);
      issue(4, 0, 32'd9, 32'd3, 11, 1, 0);
      issue(3, 0, 32'd5, 32'd6, 12, 1, 1);
      issue(4, 1, 32'd50, 32'd5, 13, 1, 1);
`ifdef EX_DIV_EN
      ex_alusel = 4; ex_aluop = 1; ex_reg1 = 32'd1000; ex_reg2 = 32'd7; ex_wd = 3; ex_wreg = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("flush_pre_stall", {31'd0, ex_stallreq}, 32'd1);
         @(posedge clk); #1;
      end
      ex_flush = 1'b1;
      @(negedge clk);
      chk("flush_wreg_o", {31'd0, ex_wreg_o}, 32'd0);
      @(posedge clk); #1;
      ex_flush = 1'b0; ex_alusel = 0; ex_wreg = 0;
      @(negedge clk);
      chk("flush_stall_drop", {31'd0, ex_stallreq}, 32'd0);
      @(posedge clk); #1;
`endif
      issue(4, 1, 32'd1000, 32'd7, 3, 1, 0);
      ex_alusel = 4; ex_aluop = 1; ex_reg1 = 32'd1000; ex_reg2 = 32'd7; ex_wd = 7; ex_wreg = 1; ex_flush = 0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_wd_o", {27'd0, ex_wd_o}, 32'd0);
      chk("midrst_wreg_o", {31'd0, ex_wreg_o}, 32'd0);
      chk("midrst_wdata", ex_wdata_o, 32'd0);
      chk("midrst_stall", {31'd0, ex_stallreq}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      issue(3, 0, 32'd3, 32'd4, 4, 1, 0);
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
         issue(3'($urandom_range(0, 7)), 7'($urandom_range(0, 4)), a, b, 5'($urandom),
               1'($urandom), $urandom_range(0, 7) == 0);
      end
      ex_alusel = 0; ex_flush = 0;
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
